// File: rtl/rps_match_controller.sv
// rps_match_controller: sequencing controller for a two-player
// rock-paper-scissors match.
//
// Collects one move per player per round over a valid/ready handshake,
// judges the round, and drives a registered result code plus a one-cycle
// score_tick that clocks downstream score counters. Keeps its own round
// and win tallies to decide when the match is over.
//
// Ports:
//   clk          in  1  rising-edge clock
//   reset        in  1  asynchronous, active-high reset
//   start        in  1  begin a new match (honoured in IDLE or DONE only)
//   p1_valid     in  1  player 1 move offered
//   p1_move      in  2  01 rock, 10 paper, 11 scissors, 00 illegal
//   p2_valid     in  1  player 2 move offered
//   p2_move      in  2  same encoding as p1_move
//   p1_ready     out 1  COLLECT and player 1 move not yet latched
//   p2_ready     out 1  COLLECT and player 2 move not yet latched
//   matchresult  out 2  00 none, 01 P1 win, 11 P2 win, 10 draw
//   score_tick   out 1  one-cycle registered pulse for the score counters
//   round_cnt    out 4  rounds completed in this match
//   p1_wins      out 4  player 1 round wins
//   p2_wins      out 4  player 2 round wins
//   game_over    out 1  high while in DONE
//   winner       out 2  match winner (matchresult encoding), valid with game_over

module rps_match_controller #(
  parameter int unsigned WIN_TARGET = 3,
  parameter int unsigned MAX_ROUNDS = 9,
  parameter int unsigned TIMEOUT    = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_valid,
  input  logic [1:0] p1_move,
  input  logic       p2_valid,
  input  logic [1:0] p2_move,
  output logic       p1_ready,
  output logic       p2_ready,
  output logic [1:0] matchresult,
  output logic       score_tick,
  output logic [3:0] round_cnt,
  output logic [3:0] p1_wins,
  output logic [3:0] p2_wins,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int unsigned MOVE_W  = 2;
  localparam int unsigned RES_W   = 2;
  localparam int unsigned TALLY_W = 4;
  localparam int unsigned TMR_W   = 8;

  localparam logic [MOVE_W-1:0] MOVE_NONE = 2'b00;
  localparam logic [MOVE_W-1:0] ROCK      = 2'b01;
  localparam logic [MOVE_W-1:0] PAPER     = 2'b10;
  localparam logic [MOVE_W-1:0] SCISSORS  = 2'b11;

  localparam logic [RES_W-1:0] RES_NONE = 2'b00;
  localparam logic [RES_W-1:0] RES_P1   = 2'b01;
  localparam logic [RES_W-1:0] RES_DRAW = 2'b10;
  localparam logic [RES_W-1:0] RES_P2   = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    JUDGE,
    TICK,
    HOLD,
    DONE
  } state_t;

  state_t             state;
  logic [MOVE_W-1:0]  p1_latched;
  logic [MOVE_W-1:0]  p2_latched;
  logic [TMR_W-1:0]   tmr;
  logic               hold_tail;

  logic               p1_have;
  logic               p2_have;
  logic               p1_take;
  logic               p2_take;
  logic               timeout_hit;
  logic               p1_at_target;
  logic               p2_at_target;
  logic               match_end;
  logic [RES_W-1:0]   round_result;
  logic [RES_W-1:0]   final_winner;

  // A latched move of 00 means "nothing latched yet"; 00 is never accepted.
  assign p1_have = (p1_latched != MOVE_NONE);
  assign p2_have = (p2_latched != MOVE_NONE);

  // Ready depends on registered state only, never on the valid inputs.
  assign p1_ready = (state == COLLECT) && !p1_have;
  assign p2_ready = (state == COLLECT) && !p2_have;

  assign p1_take = p1_valid && p1_ready && (p1_move != MOVE_NONE);
  assign p2_take = p2_valid && p2_ready && (p2_move != MOVE_NONE);

  // The timer reads 0 on the edge after the first latch, so reaching
  // TIMEOUT-1 here means this edge is TIMEOUT cycles after that latch.
  assign timeout_hit = (tmr == TMR_W'(TIMEOUT - 1));

  assign p1_at_target = (p1_wins == TALLY_W'(WIN_TARGET));
  assign p2_at_target = (p2_wins == TALLY_W'(WIN_TARGET));
  assign match_end    = p1_at_target || p2_at_target ||
                        (round_cnt == TALLY_W'(MAX_ROUNDS));

  // Round verdict; a missing move is a forfeit in favour of the submitter.
  always_comb begin
    round_result = RES_DRAW;
    if (p2_latched == MOVE_NONE) begin
      round_result = RES_P1;
    end else if (p1_latched == MOVE_NONE) begin
      round_result = RES_P2;
    end else if (p1_latched == p2_latched) begin
      round_result = RES_DRAW;
    end else if ((p1_latched == ROCK     && p2_latched == SCISSORS) ||
                 (p1_latched == PAPER    && p2_latched == ROCK)     ||
                 (p1_latched == SCISSORS && p2_latched == PAPER)) begin
      round_result = RES_P1;
    end else begin
      round_result = RES_P2;
    end
  end

  // Match verdict: target reached first, otherwise the higher tally.
  always_comb begin
    final_winner = RES_DRAW;
    if (p1_at_target) begin
      final_winner = RES_P1;
    end else if (p2_at_target) begin
      final_winner = RES_P2;
    end else if (p1_wins > p2_wins) begin
      final_winner = RES_P1;
    end else if (p2_wins > p1_wins) begin
      final_winner = RES_P2;
    end else begin
      final_winner = RES_DRAW;
    end
  end

  // Match sequencer with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      p1_latched  <= MOVE_NONE;
      p2_latched  <= MOVE_NONE;
      tmr         <= '0;
      hold_tail   <= 1'b0;
      matchresult <= RES_NONE;
      score_tick  <= 1'b0;
      round_cnt   <= '0;
      p1_wins     <= '0;
      p2_wins     <= '0;
      game_over   <= 1'b0;
      winner      <= RES_NONE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            round_cnt  <= '0;
            p1_wins    <= '0;
            p2_wins    <= '0;
            winner     <= RES_NONE;
            game_over  <= 1'b0;
            p1_latched <= MOVE_NONE;
            p2_latched <= MOVE_NONE;
            tmr        <= '0;
            state      <= COLLECT;
          end
        end

        COLLECT: begin
          if (p1_take) begin
            p1_latched <= p1_move;
          end
          if (p2_take) begin
            p2_latched <= p2_move;
          end
          // Timer idles at zero until some move is held, then counts.
          if (!p1_have && !p2_have) begin
            tmr <= '0;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
          // A real second move on the timeout edge still wins over forfeit.
          if ((p1_have || p1_take) && (p2_have || p2_take)) begin
            state <= JUDGE;
          end else if ((p1_have || p2_have) && timeout_hit) begin
            state <= JUDGE;
          end
        end

        JUDGE: begin
          matchresult <= round_result;
          round_cnt   <= round_cnt + TALLY_W'(1);
          if (round_result == RES_P1) begin
            p1_wins <= p1_wins + TALLY_W'(1);
          end else if (round_result == RES_P2) begin
            p2_wins <= p2_wins + TALLY_W'(1);
          end
          state <= TICK;
        end

        TICK: begin
          score_tick <= 1'b1;
          hold_tail  <= 1'b0;
          state      <= HOLD;
        end

        // HOLD first drops the tick, then keeps matchresult for one more
        // cycle so gating on matchresult is stable around both tick edges.
        HOLD: begin
          score_tick <= 1'b0;
          if (!hold_tail) begin
            hold_tail <= 1'b1;
          end else begin
            hold_tail   <= 1'b0;
            matchresult <= RES_NONE;
            p1_latched  <= MOVE_NONE;
            p2_latched  <= MOVE_NONE;
            tmr         <= '0;
            if (match_end) begin
              game_over <= 1'b1;
              winner    <= final_winner;
              state     <= DONE;
            end else begin
              state <= COLLECT;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rps_match_controller.sv
// tb_rps_match_controller: randomized, scoreboard-checked bench for
// rps_match_controller. A driver plays whole matches (simultaneous,
// staggered, forfeit and illegal-move rounds), a rule-level model predicts
// each round, and a monitor compares every score_tick window against the
// queued prediction. Ends with an asynchronous reset issued mid-tick.

module tb_rps_match_controller;

  localparam int WT          = 3;
  localparam int MR          = 5;
  localparam int TO          = 4;
  localparam int NUM_MATCHES = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       p1_valid = 1'b0;
  logic [1:0] p1_move = 2'b00;
  logic       p2_valid = 1'b0;
  logic [1:0] p2_move = 2'b00;
  logic       p1_ready;
  logic       p2_ready;
  logic [1:0] matchresult;
  logic       score_tick;
  logic [3:0] round_cnt;
  logic [3:0] p1_wins;
  logic [3:0] p2_wins;
  logic       game_over;
  logic [1:0] winner;

  int cyc    = 0;
  int tests  = 0;
  int failed = 0;
  bit mon_en = 1'b1;

  // Reference model state for the current match.
  int m_p1w;
  int m_p2w;
  int m_rnd;
  bit m_done;

  typedef struct {
    int cyc;
    int res;
    int p1w;
    int p2w;
    int rnd;
    bit done;
    int win;
  } exp_t;

  exp_t sb[$];

  rps_match_controller #(
    .WIN_TARGET(WT),
    .MAX_ROUNDS(MR),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .p1_valid(p1_valid),
    .p1_move(p1_move),
    .p2_valid(p2_valid),
    .p2_move(p2_move),
    .p1_ready(p1_ready),
    .p2_ready(p2_ready),
    .matchresult(matchresult),
    .score_tick(score_tick),
    .round_cnt(round_cnt),
    .p1_wins(p1_wins),
    .p2_wins(p2_wins),
    .game_over(game_over),
    .winner(winner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    p1_move  = 2'b00;
    p2_move  = 2'b00;
    start    = 1'b0;
  endtask

  // Moves 1 rock, 2 paper, 3 scissors, 0 absent. Each move beats the one
  // just below it in cyclic order, so (a - b) mod 3 == 1 means a wins.
  // Returns 1 P1 win, 3 P2 win, 2 draw.
  function automatic int outcome(input int a, input int b);
    if (a == 0) return 3;
    if (b == 0) return 1;
    if (a == b) return 2;
    return (((a - b + 3) % 3) == 1) ? 1 : 3;
  endfunction

  task automatic new_match_model();
    m_p1w  = 0;
    m_p2w  = 0;
    m_rnd  = 0;
    m_done = 1'b0;
  endtask

  task automatic push_round(input int a, input int b, input int tick_cyc);
    exp_t e;
    int   r;
    r = outcome(a, b);
    m_rnd++;
    if (r == 1) m_p1w++;
    if (r == 3) m_p2w++;
    m_done = (m_p1w == WT) || (m_p2w == WT) || (m_rnd == MR);
    e.cyc  = tick_cyc;
    e.res  = r;
    e.p1w  = m_p1w;
    e.p2w  = m_p2w;
    e.rnd  = m_rnd;
    e.done = m_done;
    if (m_p1w == WT)        e.win = 1;
    else if (m_p2w == WT)   e.win = 3;
    else if (m_p1w > m_p2w) e.win = 1;
    else if (m_p2w > m_p1w) e.win = 3;
    else                    e.win = 2;
    sb.push_back(e);
  endtask

  task automatic wait_both_ready();
    int n = 0;
    while (!(p1_ready && p2_ready) && n < 50) begin
      step();
      n++;
    end
    check("wait_both_ready", int'(p1_ready && p2_ready), 1);
  endtask

  // kind: 0 same cycle, 1 P1 first, 2 P2 first, 3 P1 forfeit win,
  //       4 P2 forfeit win, 5 illegal 00 offers then same cycle
  task automatic play_round(input int kind, input int a, input int b);
    int d;
    int f;
    int e;
    wait_both_ready();
    case (kind)
      1, 2: begin
        d = $urandom_range(1, TO - 1);
        if (kind == 1) begin
          p1_valid = 1'b1;
          p1_move  = 2'(a);
        end else begin
          p2_valid = 1'b1;
          p2_move  = 2'(b);
        end
        step();
        f = cyc;
        // Keep offering a different move; it must be ignored.
        if (kind == 1) begin
          p1_move = 2'((a % 3) + 1);
          check("p1_ready_after_latch", int'(p1_ready), 0);
        end else begin
          p2_move = 2'((b % 3) + 1);
          check("p2_ready_after_latch", int'(p2_ready), 0);
        end
        // Stray start inside COLLECT must have no effect.
        start = 1'($urandom_range(0, 1));
        for (int i = 1; i < d; i++) begin
          step();
          start = 1'b0;
        end
        if (kind == 1) begin
          p2_valid = 1'b1;
          p2_move  = 2'(b);
        end else begin
          p1_valid = 1'b1;
          p1_move  = 2'(a);
        end
        step();
        e = cyc;
        idle_inputs();
        check("second_move_gap", e - f, d);
        push_round(a, b, e + 2);
      end
      3, 4: begin
        if (kind == 3) begin
          p1_valid = 1'b1;
          p1_move  = 2'(a);
        end else begin
          p2_valid = 1'b1;
          p2_move  = 2'(b);
        end
        step();
        f = cyc;
        idle_inputs();
        if (kind == 3) begin
          check("forfeit_p2_ready_open", int'(p2_ready), 1);
          push_round(a, 0, f + TO + 2);
        end else begin
          check("forfeit_p1_ready_open", int'(p1_ready), 1);
          push_round(0, b, f + TO + 2);
        end
      end
      default: begin
        if (kind == 5) begin
          p1_valid = 1'b1;
          p1_move  = 2'b00;
          p2_valid = 1'b1;
          p2_move  = 2'b00;
          step();
          check("illegal_p1_ready", int'(p1_ready), 1);
          check("illegal_p2_ready", int'(p2_ready), 1);
        end
        p1_valid = 1'b1;
        p1_move  = 2'(a);
        p2_valid = 1'b1;
        p2_move  = 2'(b);
        step();
        e = cyc;
        idle_inputs();
        push_round(a, b, e + 2);
      end
    endcase
  endtask

  task automatic wait_round_end();
    int n = 0;
    while ((p1_ready || p2_ready) && n < 50) begin
      step();
      n++;
    end
    check("ready_drop", int'(p1_ready || p2_ready), 0);
    n = 0;
    while (!((p1_ready && p2_ready) || game_over) && n < 50) begin
      step();
      n++;
    end
    check("round_settle", int'((p1_ready && p2_ready) || game_over), 1);
    check("game_over_vs_model", int'(game_over), int'(m_done));
  endtask

  // Monitor: every score_tick is matched against the oldest prediction,
  // including the result window one cycle either side of the pulse.
  initial begin
    logic [1:0] prev_mr;
    exp_t       e;
    prev_mr = 2'b00;
    forever begin
      @(negedge clk);
      if (mon_en && score_tick) begin
        if (sb.size() == 0) begin
          check("unexpected_tick", int'(score_tick), 0);
        end else begin
          e = sb.pop_front();
          check("tick_cycle", cyc, e.cyc);
          check("mr_before_tick", int'(prev_mr), e.res);
          check("mr_at_tick", int'(matchresult), e.res);
          check("p1_wins", int'(p1_wins), e.p1w);
          check("p2_wins", int'(p2_wins), e.p2w);
          check("round_cnt", int'(round_cnt), e.rnd);
          @(negedge clk);
          check("tick_fall", int'(score_tick), 0);
          check("mr_after_tick", int'(matchresult), e.res);
          @(negedge clk);
          check("mr_clear", int'(matchresult), 0);
          check("game_over", int'(game_over), int'(e.done));
          if (e.done) check("winner", int'(winner), e.win);
        end
      end
      prev_mr = matchresult;
    end
  end

  initial begin
    int kind;
    int a;
    int b;
    int n;

    // Reset state
    @(negedge clk);
    check("rst_matchresult", int'(matchresult), 0);
    check("rst_score_tick", int'(score_tick), 0);
    check("rst_round_cnt", int'(round_cnt), 0);
    check("rst_game_over", int'(game_over), 0);
    check("rst_winner", int'(winner), 0);
    check("rst_p1_ready", int'(p1_ready), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    check("idle_p2_ready", int'(p2_ready), 0);

    for (int m = 0; m < NUM_MATCHES; m++) begin
      start = 1'b1;
      step();
      start = 1'b0;
      new_match_model();
      check("start_ready", int'(p1_ready && p2_ready), 1);
      check("start_round_cnt", int'(round_cnt), 0);
      check("start_p1_wins", int'(p1_wins), 0);
      check("start_game_over", int'(game_over), 0);
      while (!m_done) begin
        if (m == 0) begin
          kind = 0; a = 1; b = 3;            // P1 rock over scissors
        end else if (m == 1) begin
          kind = 0;
          a = $urandom_range(1, 3);
          b = a;                              // all draws to the round limit
        end else begin
          kind = $urandom_range(0, 5);
          a = $urandom_range(1, 3);
          b = $urandom_range(1, 3);
        end
        play_round(kind, a, b);
        wait_round_end();
      end
    end

    repeat (6) step();
    check("scoreboard_empty", sb.size(), 0);

    // Asynchronous reset in the middle of a score_tick
    mon_en = 1'b0;
    reset  = 1'b1;
    step();
    reset = 1'b0;
    step();
    start = 1'b1;
    step();
    start    = 1'b0;
    p1_valid = 1'b1;
    p1_move  = 2'b01;
    p2_valid = 1'b1;
    p2_move  = 2'b10;
    step();
    idle_inputs();
    n = 0;
    while (!score_tick && n < 20) begin
      step();
      n++;
    end
    check("tick_before_reset", int'(score_tick), 1);
    reset = 1'b1;
    #1;
    check("reset_tick", int'(score_tick), 0);
    check("reset_mr", int'(matchresult), 0);
    check("reset_round_cnt", int'(round_cnt), 0);
    check("reset_p2_wins", int'(p2_wins), 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("no_tick_after_reset", int'(score_tick), 0);
    end
    check("idle_after_reset", int'(p1_ready), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("ready_after_restart", int'(p1_ready && p2_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/rps_match_controller.md
# rps_match_controller

Sequencing controller for a two-player rock-paper-scissors match. It collects one move per player per round through a valid/ready handshake and judges the round. It drives the 2-bit `matchresult` code and a glitch-free `score_tick` pulse that clock the downstream score counters, and it keeps its own round and win tallies to decide when the match ends.

## Interface
Parameters:
- `WIN_TARGET`, 3: wins needed to end the match (1-15)
- `MAX_ROUNDS`, 9: round limit (1-15)
- `TIMEOUT`, 200: cycles allowed for the second move after the first is latched (1-255)

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: one clock; reset is asynchronous and active-high
- `start` in 1: begin new match; honoured only in IDLE or DONE
- `p1_valid` in 1: P1 move offered
- `p1_move` in 2: 01 rock, 10 paper, 11 scissors; 00 is illegal and ignored
- `p2_valid` in 1: P2 move offered
- `p2_move` in 2: same encoding as `p1_move`
- `p1_ready` out 1: high in COLLECT while P1 move not yet latched
- `p2_ready` out 1: high in COLLECT while P2 move not yet latched
- `matchresult` out 2: 00 none, 01 P1 win, 11 P2 win, 10 draw
- `score_tick` out 1: one-cycle registered pulse; score counters advance on it
- `round_cnt` out 4: rounds completed
- `p1_wins` out 4: P1 round wins
- `p2_wins` out 4: P2 round wins
- `game_over` out 1: high in DONE
- `winner` out 2: match winner, same encoding as `matchresult`; valid when `game_over`

## Operation
- States: IDLE, COLLECT, JUDGE, TICK, HOLD, DONE.
- Reset (async, any state): state IDLE; all outputs 0; latched moves, timeout counter and tallies cleared.
- IDLE/DONE + `start`: clear tallies, `winner`, `game_over` -> COLLECT. `start` is ignored in all other states.
- COLLECT:
  - A move is latched when `pX_valid & pX_ready` and the move is not 00. After latching, `pX_ready` drops and further offers are ignored.
  - Both players valid in the same cycle: both latched.
  - Timeout counter clears and starts when the first move is latched and counts each cycle. If it reaches `TIMEOUT` with one move missing, the round is forfeited: the submitter wins and the FSM goes to JUDGE.
  - With no move latched, the FSM waits indefinitely.
  - Both moves latched -> JUDGE.
- JUDGE (1 cycle):
  - Register `matchresult`: rock beats scissors, scissors beats paper, paper beats rock; equal moves give 10.
  - Increment `round_cnt` and the winner's tally in the same edge; a draw increments only `round_cnt`.
  - Next state TICK.
- TICK (1 cycle): `score_tick`=1, `matchresult` unchanged -> HOLD.
- HOLD (1 cycle): `score_tick`=0, `matchresult` unchanged.
  - On exit, `matchresult` returns to 00 and latched moves are cleared.
  - Go to DONE if `p1_wins`==`WIN_TARGET`, `p2_wins`==`WIN_TARGET`, or `round_cnt`==`MAX_ROUNDS`; otherwise go to COLLECT.
- DONE:
  - `game_over`=1.
  - `winner` = player reaching `WIN_TARGET`; at the round limit, the higher tally wins, and equal tallies give 10.
  - Held until `start` or `reset`.
- Tallies saturate by construction: the match ends before any tally exceeds 15.

## Timing
- Edge k samples the second move -> JUDGE. `matchresult` is valid after edge k+1, `score_tick` is high between edges k+2 and k+3, and `matchresult` clears at k+4.
- `matchresult` is stable from one full cycle before the `score_tick` rise until one full cycle after its fall, so gating the counters with `matchresult` cannot glitch.
- `pX_ready` is low from JUDGE through HOLD. The earliest next-round move is sampled at edge k+5.
- Forfeit: the first move latched at edge f gives JUDGE entry at edge f+`TIMEOUT`.
- Reset asserted mid-round: the next cycle shows IDLE values; no partial tick is emitted after reset.
- All outputs are registered; no combinational path from inputs to outputs except `pX_ready`, which is a function of state only.

## Test plan
- Reset then `start`; P1 rock and P2 scissors in the same cycle -> `matchresult`=01 for 3 cycles, one `score_tick`, `p1_wins`=1, `round_cnt`=1.
- P1 paper at cycle 3, P2 paper at cycle 7; P1 re-offers scissors at cycle 5 -> second offer ignored; `matchresult`=10; tallies unchanged except `round_cnt`.
- `TIMEOUT`=4; only P2 offers rock -> JUDGE 4 cycles later; `matchresult`=11; `p2_wins`+1.
- P1 wins 3 straight rounds with `WIN_TARGET`=3 -> DONE, `game_over`=1, `winner`=01. `start` clears the tallies and returns to COLLECT.
- `MAX_ROUNDS`=2 with draw then draw -> DONE, `winner`=10. Illegal move 00 offered -> not latched, `ready` stays high.
- Assert `reset` during TICK -> `score_tick` and `matchresult` are 0 immediately; IDLE; `start` is needed to resume.
